nios_op_executor: RTL and testbench



---
 rtl/nios_op_pkg.sv | 28 ++
 rtl/nios_op_muldiv_seq.sv | 80 ++++++++
 rtl/nios_op_executor.sv | 154 +++++++++++++++
 tb/tb_nios_op_executor.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_op_pkg.sv
// Shared definitions for the Nios accumulator coprocessor: opcodes,
// FSM states and status-word bit positions.
package nios_op_pkg;

  localparam logic [3:0] OPC_NOP = 4'd0;
  localparam logic [3:0] OPC_ADD = 4'd1;
  localparam logic [3:0] OPC_SUB = 4'd2;
  localparam logic [3:0] OPC_MUL = 4'd3;
  localparam logic [3:0] OPC_DIV = 4'd4;
  localparam logic [3:0] OPC_CLR = 4'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_ACK  = 1;
  localparam int unsigned ST_DIV0 = 2;
  localparam int unsigned ST_OVF  = 3;

  // True when the opcode needs the iterative multiply/divide unit.
  function automatic logic uses_seq(input logic [3:0] opc, input logic operand_zero);
    return (opc == OPC_MUL) || ((opc == OPC_DIV) && !operand_zero);
  endfunction

endpackage

// File: rtl/nios_op_muldiv_seq.sv
// Iterative unsigned shift-add multiplier / restoring divider.
// Fixed latency of WIDTH cycles after start; done is high during the last
// iteration and lo/hi then present the final product or quotient/remainder.
module nios_op_muldiv_seq
  import nios_op_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             running;
  logic             mode;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // One iteration step; lo/hi are the working registers after this step.
  // Multiply: {hi,lo} holds partial product with the multiplier shifting out of lo.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    sum     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd} : '0);
    shifted = {hi_r, lo_r[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (mode) begin
      if (!diff[WIDTH]) begin
        hi = diff[WIDTH-1:0];
        lo = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi = shifted[WIDTH-1:0];
        lo = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi = sum[WIDTH:1];
      lo = {sum[0], lo_r[WIDTH-1:1]};
    end
    done     = running && (count == CW'(WIDTH - 1));
    overflow = |hi;
  end

  // Operand load on start, then WIDTH iterations.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      mode    <= 1'b0;
      count   <= '0;
      lo_r    <= '0;
      hi_r    <= '0;
      opnd    <= '0;
    end else if (start) begin
      running <= 1'b1;
      mode    <= div_mode;
      count   <= '0;
      lo_r    <= a;
      hi_r    <= '0;
      opnd    <= b;
    end else if (running) begin
      lo_r  <= lo;
      hi_r  <= hi;
      count <= count + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/nios_op_executor.sv
// Accumulator coprocessor behind Nios PIOs. A request is a flip of
// operation_in[31]; completion is signalled by the ack bit matching it.
module nios_op_executor
  import nios_op_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPC_W = 4
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [31:0]      operation_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] result_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic [7:0]       status_out,
  output logic [7:0]       leds_out
);

  state_t           state;
  logic             req_r;
  logic [OPC_W-1:0] opc_r;
  logic [WIDTH-1:0] data_r;
  logic             tog_l;
  logic [OPC_W-1:0] opc_l;
  logic [WIDTH-1:0] operand_l;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] rem;
  logic             ack;
  logic             busy;
  logic             div0;
  logic             ovf;
  logic [OPC_W-1:0] last_opc;

  logic             seq_start;
  logic             seq_done;
  logic [WIDTH-1:0] seq_lo;
  logic [WIDTH-1:0] seq_hi;
  logic             seq_ovf;
  logic             op_unused;

  assign op_unused = ^operation_in[30:OPC_W];

  // Multiply/divide operands are taken straight from the input registers on
  // the IDLE->EXEC edge so the WIDTH iterations fill the EXEC state exactly.
  assign seq_start = (state == IDLE) && (req_r != ack) && uses_seq(opc_r, data_r == '0);

  nios_op_muldiv_seq #(
    .WIDTH(WIDTH)
  ) u_seq (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .start   (seq_start),
    .div_mode(opc_r == OPC_DIV),
    .a       (acc),
    .b       (data_r),
    .done    (seq_done),
    .lo      (seq_lo),
    .hi      (seq_hi),
    .overflow(seq_ovf)
  );

  // Input registers and request/execute/acknowledge sequencing.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state     <= IDLE;
      req_r     <= 1'b0;
      opc_r     <= '0;
      data_r    <= '0;
      tog_l     <= 1'b0;
      opc_l     <= '0;
      operand_l <= '0;
      acc       <= '0;
      rem       <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      div0      <= 1'b0;
      ovf       <= 1'b0;
      last_opc  <= '0;
    end else begin
      req_r  <= operation_in[31];
      opc_r  <= operation_in[OPC_W-1:0];
      data_r <= data_in;
      case (state)
        IDLE: begin
          if (req_r != ack) begin
            tog_l     <= req_r;
            opc_l     <= opc_r;
            operand_l <= data_r;
            busy      <= 1'b1;
            div0      <= 1'b0;
            ovf       <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          case (opc_l)
            OPC_ADD: begin
              acc   <= acc + operand_l;
              state <= DONE;
            end
            OPC_SUB: begin
              acc   <= acc - operand_l;
              state <= DONE;
            end
            OPC_CLR: begin
              acc   <= '0;
              rem   <= '0;
              state <= DONE;
            end
            OPC_MUL: begin
              if (seq_done) begin
                acc   <= seq_lo;
                ovf   <= seq_ovf;
                state <= DONE;
              end
            end
            OPC_DIV: begin
              if (operand_l == '0) begin
                div0  <= 1'b1;
                state <= DONE;
              end else if (seq_done) begin
                acc   <= seq_lo;
                rem   <= seq_hi;
                state <= DONE;
              end
            end
            default: state <= DONE;
          endcase
        end
        DONE: begin
          ack      <= tog_l;
          busy     <= 1'b0;
          last_opc <= opc_l;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status word and output mirrors.
  always_comb begin
    status_out          = '0;
    status_out[ST_BUSY] = busy;
    status_out[ST_ACK]  = ack;
    status_out[ST_DIV0] = div0;
    status_out[ST_OVF]  = ovf;
    status_out[7:4]     = 4'(last_opc);
    result_out          = acc;
    remainder_out       = rem;
    leds_out            = acc[7:0];
  end

endmodule

// File: tb/tb_nios_op_executor.sv
// Scoreboard bench for nios_op_executor: directed scenarios plus random ops
// against a plain-arithmetic accumulator model.
module tb_nios_op_executor;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_reset;
  logic [31:0]      operation_in;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] result_out;
  logic [WIDTH-1:0] remainder_out;
  logic [7:0]       status_out;
  logic [7:0]       leds_out;

  nios_op_executor #(
    .WIDTH(WIDTH),
    .OPC_W(4)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (reset_reset),
    .operation_in (operation_in),
    .data_in      (data_in),
    .result_out   (result_out),
    .remainder_out(remainder_out),
    .status_out   (status_out),
    .leds_out     (leds_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] rem;
    logic [7:0]  st;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] m_acc    = '0;
  logic [31:0] m_rem    = '0;
  logic        tog      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Reference model: apply one operation to the accumulator and queue the
  // response expected when the ack bit reaches toggle t.
  task automatic model_push(input logic [3:0] opc, input logic [31:0] d, input logic t);
    logic        dz;
    logic        ov;
    logic [63:0] prod;
    exp_t        e;
    dz = 1'b0;
    ov = 1'b0;
    case (opc)
      4'd1: m_acc = m_acc + d;
      4'd2: m_acc = m_acc - d;
      4'd3: begin
        prod  = 64'(m_acc) * 64'(d);
        m_acc = prod[31:0];
        ov    = (prod[63:32] != 32'd0);
      end
      4'd4: begin
        if (d == 32'd0) dz = 1'b1;
        else begin
          m_rem = m_acc % d;
          m_acc = m_acc / d;
        end
      end
      4'd5: begin
        m_acc = '0;
        m_rem = '0;
      end
      default: ;
    endcase
    e.res = m_acc;
    e.rem = m_rem;
    e.st  = {opc, ov, dz, t, 1'b0};
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for ack == t; returns cycles waited and busy-high samples.
  task automatic wait_ack(input logic t, output int unsigned lat, output int unsigned bcyc);
    lat  = 0;
    bcyc = 0;
    while (status_out[1] !== t && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (status_out[0] === 1'b1) bcyc++;
    end
    if (status_out[1] !== t) begin
      n_checks++;
      $display("FAIL ack_timeout: ack=%b after %0d cycles, required %b", status_out[1], lat, t);
    end
  endtask

  task automatic issue(input logic [3:0] opc, input logic [31:0] d);
    int unsigned lat;
    int unsigned bcyc;
    int unsigned exp_lat;
    exp_lat = (opc == 4'd3 || (opc == 4'd4 && d != 32'd0)) ? WIDTH + 3 : 4;
    @(posedge clk);
    #1;
    tog = ~tog;
    model_push(opc, d, tog);
    operation_in = {tog, 27'($urandom), opc};
    data_in      = d;
    wait_ack(tog, lat, bcyc);
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_cycles", 64'(bcyc), 64'(exp_lat - 2));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_result"}, 64'(result_out), 64'd0);
    check({tag, "_remainder"}, 64'(remainder_out), 64'd0);
    check({tag, "_status"}, 64'(status_out), 64'd0);
    check({tag, "_leds"}, 64'(leds_out), 64'd0);
  endtask

  // Monitor: every ack edge pops one expected response.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_reset === 1'b1) prev = 1'b0;
      else if (status_out[1] !== prev) begin
        prev = status_out[1];
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ack: ack=%b with no request outstanding", status_out[1]);
        end else begin
          e = exp_q.pop_front();
          check("result", 64'(result_out), 64'(e.res));
          check("remainder", 64'(remainder_out), 64'(e.rem));
          check("status", 64'(status_out), 64'(e.st));
          check("leds", 64'(leds_out), 64'(e.res[7:0]));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int unsigned lat;
    int unsigned bcyc;
    logic        t1;
    logic [3:0]  opc;
    logic [31:0] d;
    int unsigned r;

    reset_reset  = 1'b1;
    operation_in = '0;
    data_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset_reset = 1'b0;

    issue(4'd1, 32'd5);
    issue(4'd2, 32'd7);

    issue(4'd5, 32'd0);
    issue(4'd1, 32'h0001_0000);
    issue(4'd3, 32'h0001_0000);

    issue(4'd5, 32'd0);
    issue(4'd1, 32'd100);
    issue(4'd4, 32'd7);
    issue(4'd4, 32'd0);

    // Inputs disturbed during a MUL, then a second request queued while busy.
    issue(4'd1, 32'd3);
    @(posedge clk);
    #1;
    tog = ~tog;
    t1  = tog;
    d   = $urandom;
    model_push(4'd3, d, tog);
    operation_in = {tog, 27'd0, 4'd3};
    data_in      = d;
    repeat (5) @(posedge clk);
    #1;
    operation_in = {tog, 27'd0, 4'd2};
    data_in      = $urandom;
    repeat (5) @(posedge clk);
    #1;
    tog = ~tog;
    model_push(4'd1, 32'd3, tog);
    operation_in = {tog, 27'd0, 4'd1};
    data_in      = 32'd3;
    wait_ack(t1, lat, bcyc);
    check("mul_latency_busy_window", 64'(lat + 10), 64'(WIDTH + 3));
    wait_ack(tog, lat, bcyc);
    check("queued_latency", 64'(lat), 64'd3);

    // Reset part-way through a DIV aborts it without an ack.
    issue(4'd1, 32'd1000);
    @(posedge clk);
    #1;
    tog = ~tog;
    operation_in = {tog, 27'd0, 4'd4};
    data_in      = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    reset_reset  = 1'b1;
    operation_in = '0;
    data_in      = '0;
    @(posedge clk);
    #1;
    check_zero("midreset");
    reset_reset = 1'b0;
    tog   = 1'b0;
    m_acc = '0;
    m_rem = '0;
    repeat (40) @(posedge clk);
    #1;
    check("post_reset_quiet", 64'(status_out), 64'd0);
    issue(4'd1, 32'd42);

    for (int i = 0; i < 40; i++) begin
      r   = $urandom_range(0, 11);
      opc = (r <= 5) ? 4'(r) : 4'($urandom_range(6, 15));
      d   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      issue(opc, d);
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
